mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter SLOT_LEN, default 8: clocks per phase slot; one T-cycle is 4*SLOT_LEN clocks.
REQ-002 SHALL have parameter READ_LATENCY, default 2: clocks from mem_req_out to valid mem_rdata_in; elaboration SHALL fail unless READ_LATENCY+2 <= SLOT_LEN-1.
REQ-003 SHALL have a single clock and an asynchronous active-low reset, rst_n_in.
REQ-004 clk_in  in  1  system clock.
REQ-005 rst_n_in  in  1  asynchronous active-low reset.
REQ-006 cpu_req_in / cpu_we_in  in  1/1  CPU access request / write enable.
REQ-007 cpu_addr_in / cpu_wdata_in  in  16/8  CPU address / write data.
REQ-008 cpu_rdata_out / cpu_rdata_valid_out / cpu_blocked_out  out  8/1/1  CPU read data, valid pulse, lockout pulse.
REQ-009 ppu_req_in / ppu_addr_in  in  1/16  PPU read request and address (PPU is read-only).
REQ-010 ppu_rdata_out / ppu_rdata_valid_out  out  8/1  PPU read data and valid pulse.
REQ-011 ppu_mode_in  in  2  current PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 draw).
REQ-012 mem_req_out / mem_we_out  out  1/1  shared-memory access strobe / write enable.
REQ-013 mem_addr_out / mem_wdata_out / mem_rdata_in  out/out/in  16/8/8  shared-memory address, write data, read data.
REQ-014 phase_out / tclk_out  out  2/1  current slot (0 CPU, 1 PPU, 2 MEM, 3 SETTLE) / T-cycle tick.

Function
REQ-015 SHALL keep a sub counter 0..SLOT_LEN-1 and a phase register; sub wraps to 0 and phase advances CPU->PPU->MEM->SETTLE->CPU, SETTLE wrapping to CPU.
REQ-016 tclk_out SHALL be high exactly in cycles where phase=CPU and sub=0: one pulse per 4*SLOT_LEN clocks.
REQ-017 Requests SHALL be sampled only at the edge ending sub=0 of the owner's slot: cpu_* in the CPU slot, ppu_* in the PPU slot; a request absent then is not served until the next such slot.
REQ-018 A sampled, unblocked access SHALL drive mem_req_out high for exactly the sub=1 cycle, with mem_addr_out, mem_we_out and mem_wdata_out valid that cycle.
REQ-019 mem_addr_out and mem_wdata_out SHALL hold their last issued values outside sub=1; mem_we_out SHALL be 0 whenever mem_req_out is 0.
REQ-020 Read data SHALL be captured at the edge ending sub=1+READ_LATENCY; the matching *_rdata_valid_out SHALL be high for exactly the sub=2+READ_LATENCY cycle; *_rdata_out SHALL hold until the next capture.
REQ-021 A CPU write SHALL produce no cpu_rdata_valid_out pulse.
REQ-022 A CPU access is blocked when cpu_addr_in is in 0x8000-0x9FFF with ppu_mode_in=3, or in 0xFE00-0xFE9F with ppu_mode_in=2 or 3, sampled with the request.
REQ-023 A blocked access SHALL NOT assert mem_req_out and SHALL pulse cpu_blocked_out during sub=1.
REQ-024 A blocked read SHALL return cpu_rdata_out=0xFF with cpu_rdata_valid_out at the same cycle an unblocked read would have had it; a blocked write SHALL be dropped.
REQ-025 PPU accesses SHALL never be blocked.
REQ-026 MEM and SETTLE slots SHALL issue no memory access.
REQ-027 Range boundaries SHALL be inclusive: 0x9FFF and 0xFE9F are locked, 0x7FFF, 0xA000, 0xFDFF and 0xFEA0 are never locked.

Reset
REQ-028 While rst_n_in=0: phase=CPU, sub=0, tclk_out=0, and all other outputs are 0, with cpu_rdata_out=ppu_rdata_out=0x00 and mem_addr_out=0x0000.
REQ-029 The first clock edge after rst_n_in rises SHALL sample at phase=CPU, sub=0, and tclk_out SHALL be high in that first cycle.
REQ-030 Reset asserted mid-access SHALL abort the access: no later mem_req_out pulse and no later valid pulse from it.

Verification
REQ-031 Free-run after reset, no requests -> tclk_out high every 32 clocks; phase_out steps 0,1,2,3 every 8 clocks; mem_req_out stays 0.
REQ-032 CPU read 0xC000, mem_rdata_in=0x5A, ppu_mode_in=3 -> mem_req_out at sub=1 with mem_addr_out=0xC000 and mem_we_out=0; cpu_rdata_out=0x5A with valid at sub=4.
REQ-033 CPU read 0x9FFF with mode 3, then 0xFE9F with mode 2 -> no mem_req_out, cpu_blocked_out at sub=1, cpu_rdata_out=0xFF with valid at sub=4; 0xA000 with mode 3 -> served normally.
REQ-034 CPU write 0x8000, data 0x77, mode 0 -> mem_we_out=1, mem_wdata_out=0x77 at sub=1, no valid pulse; the same write in mode 3 -> dropped, cpu_blocked_out pulses.
REQ-035 CPU and PPU requesting continuously, PPU addr 0x9800, mode 3 -> CPU grant at global clock 1 mod 32, PPU grant at 9 mod 32; PPU valid at 12 mod 32; a CPU request raised at sub=3 is served in the next CPU slot.
REQ-036 rst_n_in pulsed low at sub=2 of a CPU read -> all outputs 0 immediately; no valid pulse afterwards; tclk_out high in the first cycle after release.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                   |
// | Purpose  : Time-sliced arbiter giving a CPU and a PPU access to one      |
// |            shared memory. A T-cycle is four slots of SLOT_LEN clocks     |
// |            (CPU, PPU, MEM, SETTLE); only the CPU and PPU slots issue     |
// |            accesses. CPU accesses to VRAM/OAM are locked out depending   |
// |            on the PPU mode: blocked reads return 0xFF, blocked writes    |
// |            are dropped.                                                  |
// | Ports    : clk_in, rst_n_in            clock, async active-low reset     |
// |            cpu_req/we/addr/wdata_in    CPU request                       |
// |            cpu_rdata/rdata_valid/blocked_out  CPU response               |
// |            ppu_req/addr_in             PPU read request                  |
// |            ppu_rdata/rdata_valid_out   PPU response                      |
// |            ppu_mode_in                 PPU mode (0 HB,1 VB,2 OAM,3 draw) |
// |            mem_req/we/addr/wdata_out, mem_rdata_in  shared memory port   |
// |            phase_out, tclk_out         current slot, T-cycle tick        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int SLOT_LEN     = 8,
  parameter int READ_LATENCY = 2
) (
  input  wire logic        clk_in,
  input  wire logic        rst_n_in,
  input  wire logic        cpu_req_in,
  input  wire logic        cpu_we_in,
  input  wire logic [15:0] cpu_addr_in,
  input  wire logic [7:0]  cpu_wdata_in,
  output logic [7:0]       cpu_rdata_out,
  output logic             cpu_rdata_valid_out,
  output logic             cpu_blocked_out,
  input  wire logic        ppu_req_in,
  input  wire logic [15:0] ppu_addr_in,
  output logic [7:0]       ppu_rdata_out,
  output logic             ppu_rdata_valid_out,
  input  wire logic [1:0]  ppu_mode_in,
  output logic             mem_req_out,
  output logic             mem_we_out,
  output logic [15:0]      mem_addr_out,
  output logic [7:0]       mem_wdata_out,
  input  wire logic [7:0]  mem_rdata_in,
  output logic [1:0]       phase_out,
  output logic             tclk_out
);

  localparam int SW = (SLOT_LEN > 2) ? $clog2(SLOT_LEN) : 1;
  localparam logic [SW-1:0] c_sub_last = SW'(SLOT_LEN - 1);
  // Read data is stable at the end of sub = 1 + READ_LATENCY.
  localparam logic [SW-1:0] c_sub_cap  = SW'(READ_LATENCY + 1);

  generate
    if (READ_LATENCY + 2 > SLOT_LEN - 1) begin : g_bad_latency
      $error("mem_arbiter: READ_LATENCY+2 must not exceed SLOT_LEN-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    PH_CPU    = 2'd0,
    PH_PPU    = 2'd1,
    PH_MEM    = 2'd2,
    PH_SETTLE = 2'd3
  } phase_t;

  phase_t        r_phase;
  logic [SW-1:0] r_sub;

  // Outstanding read bookkeeping between issue (sub=0 edge) and capture.
  logic r_rd_cpu;
  logic r_rd_ppu;
  logic r_rd_blk;

  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_valid;
  logic        r_cpu_blocked;
  logic [7:0]  r_ppu_rdata;
  logic        r_ppu_valid;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;

  logic w_vram_lock;
  logic w_oam_lock;
  logic w_cpu_lock;
  logic w_slot_start;

  // Inclusive lock windows: VRAM during draw, OAM during scan and draw.
  assign w_vram_lock  = (cpu_addr_in >= 16'h8000) && (cpu_addr_in <= 16'h9FFF) &&
                        (ppu_mode_in == 2'd3);
  assign w_oam_lock   = (cpu_addr_in >= 16'hFE00) && (cpu_addr_in <= 16'hFE9F) &&
                        (ppu_mode_in[1] == 1'b1);
  assign w_cpu_lock   = w_vram_lock || w_oam_lock;
  assign w_slot_start = (r_sub == '0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_phase       <= PH_CPU;
      r_sub         <= '0;
      r_rd_cpu      <= 1'b0;
      r_rd_ppu      <= 1'b0;
      r_rd_blk      <= 1'b0;
      r_cpu_rdata   <= 8'h00;
      r_cpu_valid   <= 1'b0;
      r_cpu_blocked <= 1'b0;
      r_ppu_rdata   <= 8'h00;
      r_ppu_valid   <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 16'h0000;
      r_mem_wdata   <= 8'h00;
    end else begin
      // Slot timebase
      if (r_sub == c_sub_last) begin
        r_sub <= '0;
        case (r_phase)
          PH_CPU:  r_phase <= PH_PPU;
          PH_PPU:  r_phase <= PH_MEM;
          PH_MEM:  r_phase <= PH_SETTLE;
          default: r_phase <= PH_CPU;
        endcase
      end else begin
        r_sub <= r_sub + 1'b1;
      end

      // Single-cycle strobes default low.
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_cpu_blocked <= 1'b0;
      r_cpu_valid   <= 1'b0;
      r_ppu_valid   <= 1'b0;

      // Request sampling at the edge ending sub=0 of the owner's slot.
      if (w_slot_start) begin
        r_rd_cpu <= 1'b0;
        r_rd_ppu <= 1'b0;
        r_rd_blk <= 1'b0;
        if (r_phase == PH_CPU && cpu_req_in) begin
          r_rd_cpu <= !cpu_we_in;
          if (w_cpu_lock) begin
            r_cpu_blocked <= 1'b1;
            r_rd_blk      <= 1'b1;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= cpu_we_in;
            r_mem_addr <= cpu_addr_in;
            if (cpu_we_in) begin
              r_mem_wdata <= cpu_wdata_in;
            end
          end
        end else if (r_phase == PH_PPU && ppu_req_in) begin
          r_rd_ppu   <= 1'b1;
          r_mem_req  <= 1'b1;
          r_mem_addr <= ppu_addr_in;
        end
      end

      // Capture read data; valid is high during the following cycle.
      if (r_sub == c_sub_cap) begin
        if (r_rd_cpu) begin
          r_cpu_rdata <= r_rd_blk ? 8'hFF : mem_rdata_in;
          r_cpu_valid <= 1'b1;
        end
        if (r_rd_ppu) begin
          r_ppu_rdata <= mem_rdata_in;
          r_ppu_valid <= 1'b1;
        end
        r_rd_cpu <= 1'b0;
        r_rd_ppu <= 1'b0;
        r_rd_blk <= 1'b0;
      end
    end
  end

  assign cpu_rdata_out       = r_cpu_rdata;
  assign cpu_rdata_valid_out = r_cpu_valid;
  assign cpu_blocked_out     = r_cpu_blocked;
  assign ppu_rdata_out       = r_ppu_rdata;
  assign ppu_rdata_valid_out = r_ppu_valid;
  assign mem_req_out         = r_mem_req;
  assign mem_we_out          = r_mem_we;
  assign mem_addr_out        = r_mem_addr;
  assign mem_wdata_out       = r_mem_wdata;
  assign phase_out           = r_phase;
  // Gated by reset so the tick is low while held in reset and high in the
  // very first cycle after release, before any clock edge has occurred.
  assign tclk_out            = rst_n_in && (r_phase == PH_CPU) && w_slot_start;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                |
// | Purpose  : Self-checking bench for mem_arbiter (SLOT_LEN=8, latency 2).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic [7:0]  cpu_rdata;
  logic        cpu_valid;
  logic        cpu_blocked;
  logic        ppu_req = 1'b0;
  logic [15:0] ppu_addr = 16'h0;
  logic [7:0]  ppu_rdata;
  logic        ppu_valid;
  logic [1:0]  ppu_mode = 2'd0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h0;
  logic [1:0]  phase;
  logic        tclk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] last_cpu_rdata = 8'h00;

  mem_arbiter #(.SLOT_LEN(8), .READ_LATENCY(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .cpu_req_in(cpu_req), .cpu_we_in(cpu_we), .cpu_addr_in(cpu_addr),
    .cpu_wdata_in(cpu_wdata), .cpu_rdata_out(cpu_rdata),
    .cpu_rdata_valid_out(cpu_valid), .cpu_blocked_out(cpu_blocked),
    .ppu_req_in(ppu_req), .ppu_addr_in(ppu_addr), .ppu_rdata_out(ppu_rdata),
    .ppu_rdata_valid_out(ppu_valid), .ppu_mode_in(ppu_mode),
    .mem_req_out(mem_req), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
    .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata),
    .phase_out(phase), .tclk_out(tclk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [1:0]  mode;
    logic [7:0]  mdata;
    logic        exp_blk;
    logic        exp_val;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference lock rule, straight from the address windows and PPU mode.
  function automatic bit ref_locked(input logic [15:0] a, input logic [1:0] m);
    int ai = int'(a);
    return ((ai >= 'h8000 && ai <= 'h9FFF) && m == 2'd3) ||
           ((ai >= 'hFE00 && ai <= 'hFE9F) && (m == 2'd2 || m == 2'd3));
  endfunction

  // Returns at a negedge inside a CPU sub=0 cycle.
  task automatic wait_tclk();
    bit seen = 0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (tclk === 1'b1) seen = 1;
    end
    if (!seen) chk("tclk_timeout", 64'd0, 64'd1);
  endtask

  task automatic cpu_tx(input string nm, input logic [15:0] a, input logic we,
                        input logic [7:0] wd, input logic [1:0] md, input logic [7:0] mdata,
                        input logic eb, input logic ev, input logic [7:0] erd);
    wait_tclk();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; ppu_mode = md;
    @(negedge clk); // sub=1
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; mem_rdata = mdata;
    chk({nm, "_memreq"}, 64'(mem_req), 64'(!eb));
    chk({nm, "_blocked"}, 64'(cpu_blocked), 64'(eb));
    if (!eb) begin
      chk({nm, "_addr"}, 64'(mem_addr), 64'(a));
      chk({nm, "_we"}, 64'(mem_we), 64'(we));
      if (we) chk({nm, "_wdata"}, 64'(mem_wdata), 64'(wd));
    end else begin
      chk({nm, "_we_blk"}, 64'(mem_we), 64'd0);
    end
    @(negedge clk); // sub=2
    chk({nm, "_s2"}, 64'({mem_req, mem_we, cpu_valid, cpu_blocked}), 64'd0);
    @(negedge clk); // sub=3
    @(negedge clk); // sub=4
    mem_rdata = ~mdata;
    chk({nm, "_valid"}, 64'(cpu_valid), 64'(ev));
    chk({nm, "_rdata"}, 64'(cpu_rdata), 64'(erd));
    @(negedge clk); // sub=5
    chk({nm, "_s5"}, 64'(cpu_valid), 64'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    cpu_addr = 16'hFFFF; ppu_req = 1'b1; cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({cpu_rdata, cpu_valid, cpu_blocked, ppu_rdata, ppu_valid,
                         mem_req, mem_we, mem_addr, mem_wdata, phase, tclk}), 64'd0);
    cpu_req = 1'b0; ppu_req = 1'b0; cpu_addr = 16'h0;

    // ---------------- free run ----------------
    begin
      int bad_t = 0, bad_p = 0, bad_m = 0;
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 96; i++) begin
        if (i > 0) @(negedge clk);
        if (tclk !== ((i % 32) == 0)) bad_t++;
        if (phase !== 2'((i / 8) % 4)) bad_p++;
        if (mem_req !== 1'b0) bad_m++;
      end
      chk("freerun_tclk", 64'(bad_t), 64'd0);
      chk("freerun_phase", 64'(bad_p), 64'd0);
      chk("freerun_memreq", 64'(bad_m), 64'd0);
    end

    // ---------------- table vectors ----------------
    vecs[0]  = '{16'hC000, 1'b0, 8'h00, 2'd3, 8'h5A, 1'b0, 1'b1, 8'h5A};
    vecs[1]  = '{16'h9FFF, 1'b0, 8'h00, 2'd3, 8'h12, 1'b1, 1'b1, 8'hFF};
    vecs[2]  = '{16'hFE9F, 1'b0, 8'h00, 2'd2, 8'h34, 1'b1, 1'b1, 8'hFF};
    vecs[3]  = '{16'hA000, 1'b0, 8'h00, 2'd3, 8'h3C, 1'b0, 1'b1, 8'h3C};
    vecs[4]  = '{16'h8000, 1'b1, 8'h77, 2'd0, 8'h99, 1'b0, 1'b0, 8'h3C};
    vecs[5]  = '{16'h8000, 1'b1, 8'h77, 2'd3, 8'h99, 1'b1, 1'b0, 8'h3C};
    vecs[6]  = '{16'h7FFF, 1'b0, 8'h00, 2'd3, 8'h11, 1'b0, 1'b1, 8'h11};
    vecs[7]  = '{16'hFDFF, 1'b0, 8'h00, 2'd3, 8'h22, 1'b0, 1'b1, 8'h22};
    vecs[8]  = '{16'hFEA0, 1'b0, 8'h00, 2'd2, 8'h33, 1'b0, 1'b1, 8'h33};
    vecs[9]  = '{16'h8000, 1'b0, 8'h00, 2'd2, 8'h44, 1'b0, 1'b1, 8'h44};
    vecs[10] = '{16'hFE00, 1'b0, 8'h00, 2'd3, 8'h55, 1'b1, 1'b1, 8'hFF};
    vecs[11] = '{16'h9FFF, 1'b0, 8'h00, 2'd0, 8'h66, 1'b0, 1'b1, 8'h66};
    for (int v = 0; v < 12; v++) begin
      cpu_tx($sformatf("vec%0d", v), vecs[v].addr, vecs[v].we, vecs[v].wdata,
             vecs[v].mode, vecs[v].mdata, vecs[v].exp_blk, vecs[v].exp_val, vecs[v].exp_rd);
    end
    last_cpu_rdata = 8'h66;

    // ---------------- randomized CPU accesses vs reference model ----------------
    for (int r = 0; r < 40; r++) begin
      logic [15:0] a;
      logic        we;
      logic [7:0]  wd, md_data;
      logic [1:0]  md;
      bit          lk;
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range('h7FF0, 'hA00F));
        1: a = 16'($urandom_range('hFDF0, 'hFEAF));
        default: a = 16'($urandom);
      endcase
      we = 1'($urandom);
      wd = 8'($urandom);
      md = 2'($urandom);
      md_data = 8'($urandom);
      lk = ref_locked(a, md);
      if (!we) last_cpu_rdata = lk ? 8'hFF : md_data;
      cpu_tx($sformatf("rnd%0d", r), a, we, wd, md, md_data, lk, !we, last_cpu_rdata);
    end

    // ---------------- continuous CPU + PPU requests from reset ----------------
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    begin
      int bad_req = 0, bad_addr = 0, bad_pv = 0, bad_cv = 0, bad_rd = 0;
      rst_n = 1'b1;
      ppu_mode = 2'd3; ppu_addr = 16'h9800; cpu_addr = 16'hC000; cpu_we = 1'b0;
      #1;
      for (int i = 0; i < 128; i++) begin
        bit cpu_gnt, ppu_gnt;
        if (i > 0) @(negedge clk);
        // CPU request dropped at sub=0 of the third slot, raised again at sub=3.
        cpu_req = !(i >= 64 && i < 67);
        ppu_req = 1'b1;
        mem_rdata = 8'(i * 7 + 3);
        cpu_gnt = ((i % 32) == 1) && (i != 65);
        ppu_gnt = ((i % 32) == 9);
        if (mem_req !== (cpu_gnt || ppu_gnt)) bad_req++;
        if (cpu_gnt && mem_addr !== 16'hC000) bad_addr++;
        if (ppu_gnt && mem_addr !== 16'h9800) bad_addr++;
        if (ppu_valid !== ((i % 32) == 12)) bad_pv++;
        if (cpu_valid !== (((i % 32) == 4) && (i != 68))) bad_cv++;
        if ((i % 32) == 12 && ppu_rdata !== 8'((i - 1) * 7 + 3)) bad_rd++;
        if ((i % 32) == 4 && i != 68 && cpu_rdata !== 8'((i - 1) * 7 + 3)) bad_rd++;
      end
      chk("cont_memreq", 64'(bad_req), 64'd0);
      chk("cont_addr", 64'(bad_addr), 64'd0);
      chk("cont_ppu_valid", 64'(bad_pv), 64'd0);
      chk("cont_cpu_valid", 64'(bad_cv), 64'd0);
      chk("cont_rdata", 64'(bad_rd), 64'd0);
      cpu_req = 1'b0; ppu_req = 1'b0;
    end

    // ---------------- reset in the middle of a CPU read ----------------
    cpu_tx("pre_wr", 16'hC123, 1'b1, 8'hA5, 2'd0, 8'h00, 1'b0, 1'b0, cpu_rdata);
    wait_tclk();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC000; ppu_mode = 2'd0;
    @(negedge clk); // sub=1
    cpu_req = 1'b0; mem_rdata = 8'hC3;
    chk("mid_issue", 64'(mem_req), 64'd1);
    @(negedge clk); // sub=2
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({cpu_rdata, cpu_valid, cpu_blocked, ppu_rdata, ppu_valid,
                             mem_req, mem_we, mem_addr, mem_wdata, phase, tclk}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_tclk", 64'(tclk), 64'd1);
    begin
      int stray = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (cpu_valid !== 1'b0 || mem_req !== 1'b0 || ppu_valid !== 1'b0) stray++;
      end
      chk("mid_no_stray", 64'(stray), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
